// File: rtl/prbs_pkg.sv
// Shared definitions for the 8-bit PRBS generator/checker pair.
// Taps 7,5,4,2, shift left, feedback inserted at bit 0.
package prbs_pkg;

    localparam int LFSR_W = 8;
    localparam int TAP_A  = 7;
    localparam int TAP_B  = 5;
    localparam int TAP_C  = 4;
    localparam int TAP_D  = 2;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_state_e;

    function automatic logic prbs_next_bit(input logic [LFSR_W-1:0] sr);
        return sr[TAP_A] ^ sr[TAP_B] ^ sr[TAP_C] ^ sr[TAP_D];
    endfunction

endpackage

// File: rtl/prbs_err_window.sv
// Sliding error-density monitor used while the checker is locked: counts
// errors over fixed windows of valid bits and flags when the threshold is hit.
module prbs_err_window
    import prbs_pkg::*;
#(
    parameter int WINDOW     = 64,
    parameter int ERR_THRESH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic err,
    input  logic restart,
    output logic thresh_hit
);

    localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int ERR_W = $clog2(ERR_THRESH + 1);

    logic [WIN_W-1:0] win_q, win_d;
    logic [ERR_W-1:0] werr_q, werr_d;
    logic             wrap;

    always_comb begin
        win_d      = win_q;
        werr_d     = werr_q;
        thresh_hit = 1'b0;
        wrap       = (win_q == WIN_W'(WINDOW - 1));
        if (restart) begin
            win_d  = '0;
            werr_d = '0;
        end else if (step) begin
            // The wrapping bit opens the new window, so its error seeds it.
            win_d      = wrap ? '0 : win_q + 1'b1;
            werr_d     = wrap ? ERR_W'(err) : werr_q + ERR_W'(err);
            thresh_hit = (werr_d >= ERR_W'(ERR_THRESH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q  <= '0;
            werr_q <= '0;
        end else begin
            win_q  <= win_d;
            werr_q <= werr_d;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising receive-side checker for the 8-bit Fibonacci PRBS:
// hunts for a non-zero seed, verifies predictions, then counts bit errors.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT   = 16,
    parameter int WINDOW     = 64,
    parameter int ERR_THRESH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [1:0]       state
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int FILL_W  = $clog2(LFSR_W + 1);

    prbs_state_e         state_q, state_d;
    logic [LFSR_W-1:0]   sr_q, sr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic                err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;

    logic                pred;
    logic                step;
    logic                err;
    logic                restart;
    logic                thresh_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign pred    = prbs_next_bit(sr_q);
    assign step    = bit_valid && (state_q == LOCKED);
    assign err     = step && (bit_in != pred);
    assign restart = (state_q != LOCKED);

    prbs_err_window #(
        .WINDOW     (WINDOW),
        .ERR_THRESH (ERR_THRESH)
    ) u_err_window (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .err        (err),
        .restart    (restart),
        .thresh_hit (thresh_hit)
    );

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        if (bit_valid) begin
            unique case (state_q)
                HUNT: begin
                    sr_d   = {sr_q[LFSR_W-2:0], bit_in};
                    fill_d = (fill_q == FILL_W'(LFSR_W)) ? fill_q : fill_q + 1'b1;
                    if ((fill_d == FILL_W'(LFSR_W)) && (sr_d != '0)) begin
                        state_d = VERIFY;
                        match_d = '0;
                    end
                end
                VERIFY: begin
                    sr_d = {sr_q[LFSR_W-2:0], bit_in};
                    if (sr_d == '0) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end else if (bit_in == pred) begin
                        match_d = match_q + 1'b1;
                        if (match_d == MATCH_W'(LOCK_CNT)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so one line error costs one count.
                    sr_d        = {sr_q[LFSR_W-2:0], pred};
                    err_pulse_d = err;
                    bit_cnt_d   = sat_inc(bit_cnt_q);
                    if (err) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                    if (thresh_hit) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end
                end
                default: begin
                    state_d = HUNT;
                    fill_d  = '0;
                end
            endcase
        end
        if (clr) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign state     = state_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scenario bench for prbs_checker with a bit-history reference model.
module tb_prbs_checker;

    localparam int LOCK_CNT   = 16;
    localparam int WINDOW     = 64;
    localparam int ERR_THRESH = 8;
    localparam int CNT_W      = 16;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic             bit_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [1:0]       state;

    int n_vec = 0;
    int n_err = 0;

    prbs_checker #(
        .LOCK_CNT   (LOCK_CNT),
        .WINDOW     (WINDOW),
        .ERR_THRESH (ERR_THRESH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .bit_cnt   (bit_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Generator side: emits the newly inserted bit each step.
    logic [7:0] g;

    task automatic gen_bit(output logic b);
        g = {g[6:0], g[7] ^ g[5] ^ g[4] ^ g[2]};
        b = g[0];
    endtask

    // Reference model: history of the last 8 bits, oldest first.
    bit hist[$];
    int m_state, m_fill, m_match, m_idx, m_werr, m_errs, m_bits;
    bit m_pulse;

    function automatic void m_reset();
        hist.delete();
        for (int i = 0; i < 8; i++) hist.push_back(1'b0);
        m_state = 0; m_fill = 0; m_match = 0; m_idx = 0;
        m_werr = 0; m_errs = 0; m_bits = 0; m_pulse = 1'b0;
    endfunction

    function automatic bit m_all_zero();
        int ones = 0;
        foreach (hist[i]) ones += int'(hist[i]);
        return (ones == 0);
    endfunction

    function automatic void m_push(input bit b);
        hist.push_back(b);
        void'(hist.pop_front());
    endfunction

    function automatic void m_step(input bit b, input bit v, input bit c);
        bit p, e;
        m_pulse = 1'b0;
        if (v) begin
            // s[n] predicted from s[n-8], s[n-6], s[n-5], s[n-3]
            p = hist[0] ^ hist[2] ^ hist[3] ^ hist[5];
            if (m_state == 0) begin
                m_push(b);
                if (m_fill < 8) m_fill++;
                if (m_fill == 8 && !m_all_zero()) begin
                    m_state = 1; m_match = 0;
                end
            end else if (m_state == 1) begin
                m_push(b);
                if (m_all_zero()) begin
                    m_state = 0; m_fill = 0;
                end else if (b == p) begin
                    m_match++;
                    if (m_match == LOCK_CNT) begin
                        m_state = 2; m_idx = 0; m_werr = 0;
                    end
                end else begin
                    m_match = 0;
                end
            end else begin
                m_push(p);
                e = (b != p);
                m_pulse = e;
                if (m_bits < CNT_MAX) m_bits++;
                if (e && m_errs < CNT_MAX) m_errs++;
                if ((m_idx % WINDOW) == WINDOW - 1) m_werr = int'(e);
                else m_werr += int'(e);
                m_idx++;
                if (m_werr >= ERR_THRESH) begin
                    m_state = 0; m_fill = 0;
                end
            end
        end
        if (c) begin
            m_errs = 0; m_bits = 0;
        end
    endfunction

    task automatic drive(input logic b, input logic v, input logic c);
        @(negedge clk);
        bit_in = b; bit_valid = v; clr = c;
        @(posedge clk);
        #1;
        m_step(b, v, c);
        bit_valid = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        m_reset();
    endtask

    task automatic lock_up();
        logic b;
        do_reset();
        g = 8'hA5;
        for (int i = 0; i < 24; i++) begin
            gen_bit(b);
            drive(b, 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got %b want 0", locked); end
        n_vec++; if (err_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse got %b want 0", err_pulse); end
        n_vec++; if (err_cnt !== '0) begin n_err++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
        n_vec++; if (bit_cnt !== '0) begin n_err++; $display("FAIL reset_bit_cnt got %0d want 0", bit_cnt); end
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_lock();
        logic b;
        do_reset();
        g = 8'hA5;
        for (int i = 1; i <= 34; i++) begin
            gen_bit(b);
            drive(b, 1'b1, 1'b0);
            n_vec++; if (err_pulse !== 1'b0) begin n_err++; $display("FAIL lock_pulse bit %0d got %b want 0", i, err_pulse); end
            n_vec++; if (state !== 2'(m_state)) begin n_err++; $display("FAIL lock_state_model bit %0d got %0d want %0d", i, state, m_state); end
            if (i == 7) begin
                n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL lock_hunt7 got %0d want 0", state); end
            end
            if (i == 8) begin
                n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL lock_verify8 got %0d want 1", state); end
            end
            if (i == 23) begin
                n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL lock_early23 got %b want 0", locked); end
            end
            if (i == 24) begin
                n_vec++; if (locked !== 1'b1 || state !== 2'd2) begin n_err++; $display("FAIL lock_at24 got locked=%b state=%0d want 1/2", locked, state); end
            end
        end
        n_vec++; if (bit_cnt !== 16'd10) begin n_err++; $display("FAIL lock_bit_cnt got %0d want 10", bit_cnt); end
    endtask

    task automatic test_gaps();
        logic b, v;
        int nvalid = 0;
        int since_lock = 0;
        do_reset();
        g = 8'hA5;
        for (int cyc = 0; cyc < 200 && nvalid < 40; cyc++) begin
            v = ($urandom_range(0, 2) != 0);
            if (v) begin
                gen_bit(b);
                nvalid++;
                if (nvalid > 24) since_lock++;
            end else begin
                b = 1'($urandom);
            end
            drive(b, v, 1'b0);
            n_vec++; if (locked !== (nvalid >= 24)) begin n_err++; $display("FAIL gaps_locked valid=%0d got %b want %b", nvalid, locked, nvalid >= 24); end
            n_vec++; if (bit_cnt !== CNT_W'(since_lock)) begin n_err++; $display("FAIL gaps_bit_cnt got %0d want %0d", bit_cnt, since_lock); end
        end
        n_vec++; if (nvalid < 40) begin n_err++; $display("FAIL gaps_budget got %0d valid bits want 40", nvalid); end
    endtask

    task automatic test_single_err();
        logic b;
        lock_up();
        repeat (5) begin gen_bit(b); drive(b, 1'b1, 1'b0); end
        gen_bit(b);
        drive(~b, 1'b1, 1'b0);
        n_vec++; if (err_pulse !== 1'b1) begin n_err++; $display("FAIL single_pulse got %b want 1", err_pulse); end
        n_vec++; if (err_cnt !== 16'd1) begin n_err++; $display("FAIL single_err_cnt got %0d want 1", err_cnt); end
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL single_locked got %b want 1", locked); end
        for (int i = 0; i < 20; i++) begin
            gen_bit(b);
            drive(b, 1'b1, 1'b0);
            n_vec++; if (err_pulse !== 1'b0 || err_cnt !== 16'd1) begin n_err++; $display("FAIL single_after bit %0d got pulse=%b cnt=%0d want 0/1", i, err_pulse, err_cnt); end
        end
    endtask

    task automatic test_thresh();
        logic b;
        bit e;
        lock_up();
        for (int i = 0; i < 3 * WINDOW; i++) begin
            gen_bit(b);
            e = ((i % WINDOW) >= 1) && ((i % WINDOW) <= 7);
            drive(b ^ e, 1'b1, 1'b0);
            n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL thresh7_locked bit %0d got %b want 1", i, locked); end
        end
        n_vec++; if (err_cnt !== 16'd21) begin n_err++; $display("FAIL thresh7_err_cnt got %0d want 21", err_cnt); end
        lock_up();
        for (int k = 1; k <= 8; k++) begin
            gen_bit(b);
            drive(~b, 1'b1, 1'b0);
            if (k < 8) begin
                n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL thresh8_early err %0d got %b want 1", k, locked); end
            end
        end
        n_vec++; if (locked !== 1'b0 || state !== 2'd0) begin n_err++; $display("FAIL thresh8_drop got locked=%b state=%0d want 0/0", locked, state); end
        n_vec++; if (err_cnt !== 16'd8) begin n_err++; $display("FAIL thresh8_err_cnt got %0d want 8", err_cnt); end
    endtask

    task automatic test_zeros();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            n_vec++; if (state !== 2'd0 || locked !== 1'b0) begin n_err++; $display("FAIL zeros bit %0d got state=%0d locked=%b want 0/0", i, state, locked); end
        end
    endtask

    task automatic test_clr_err();
        logic b;
        lock_up();
        gen_bit(b);
        drive(~b, 1'b1, 1'b0);
        n_vec++; if (err_cnt !== 16'd1) begin n_err++; $display("FAIL clr_pre got %0d want 1", err_cnt); end
        gen_bit(b);
        drive(~b, 1'b1, 1'b1);
        n_vec++; if (err_cnt !== 16'd0 || bit_cnt !== 16'd0) begin n_err++; $display("FAIL clr_cnts got err=%0d bits=%0d want 0/0", err_cnt, bit_cnt); end
        n_vec++; if (err_pulse !== 1'b1) begin n_err++; $display("FAIL clr_pulse got %b want 1", err_pulse); end
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL clr_locked got %b want 1", locked); end
    endtask

    task automatic test_random();
        logic b, v, c;
        bit e;
        lock_up();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 40) == 0);
            e = ($urandom_range(0, 11) == 0);
            if (v) begin gen_bit(b); b = b ^ e; end
            else b = 1'($urandom);
            drive(b, v, c);
            n_vec++;
            if (state !== 2'(m_state) || locked !== (m_state == 2) || err_pulse !== m_pulse ||
                err_cnt !== CNT_W'(m_errs) || bit_cnt !== CNT_W'(m_bits)) begin
                n_err++;
                $display("FAIL random cyc %0d got st=%0d lk=%b p=%b e=%0d b=%0d want st=%0d p=%b e=%0d b=%0d",
                         i, state, locked, err_pulse, err_cnt, bit_cnt, m_state, m_pulse, m_errs, m_bits);
            end
        end
    endtask

    task automatic test_rst_locked();
        logic b;
        lock_up();
        gen_bit(b);
        drive(~b, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (state !== 2'd0 || locked !== 1'b0) begin n_err++; $display("FAIL rst_mid_state got state=%0d locked=%b want 0/0", state, locked); end
        n_vec++; if (err_cnt !== '0 || bit_cnt !== '0 || err_pulse !== 1'b0) begin n_err++; $display("FAIL rst_mid_outputs got e=%0d b=%0d p=%b want 0", err_cnt, bit_cnt, err_pulse); end
        rst = 1'b0;
        m_reset();
    endtask

    initial begin
        m_reset();
        test_reset();
        test_lock();
        test_gaps();
        test_single_err();
        test_thresh();
        test_zeros();
        test_clr_err();
        test_random();
        test_rst_locked();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side companion to the team's 8-bit Fibonacci LFSR generator. The generator uses taps 7,5,4,2, shifts left, and inserts feedback at bit 0.
- Consumes the serial bit stream (the generator's d[0] per step), self-synchronises to the sequence, then counts bit errors.
- Sits at the sink end of the PRBS test path, e.g. after a serial link or loopback, and reports lock status and error statistics.

Parameters:
- LOCK_CNT, 16: consecutive correct predictions required in VERIFY before declaring lock.
- WINDOW, 64: length, in valid bits, of the error-monitoring window while LOCKED.
- ERR_THRESH, 8: errors within one window that force loss of lock.
- CNT_W, 16: width of the err_cnt and bit_cnt statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear of err_cnt and bit_cnt only; does not affect lock
- bit_in  in  1  received PRBS bit
- bit_valid  in  1  bit_in is sampled on a posedge only when this is high
- locked  out  1  high while in LOCKED
- err_pulse  out  1  one-cycle pulse per detected error
- err_cnt  out  CNT_W  saturating count of errors detected in LOCKED
- bit_cnt  out  CNT_W  saturating count of bits checked in LOCKED
- state  out  2  0=HUNT, 1=VERIFY, 2=LOCKED

Behaviour:
- Internal state: 8-bit shift register sr, shifted left with the new bit entering sr[0].
- Predicted bit: pred = sr[7]^sr[5]^sr[4]^sr[2].
- On rst:
  - state=HUNT; sr, fill count, match count, window count and window error count all 0.
  - locked=0, err_pulse=0, err_cnt=0, bit_cnt=0.
  - A reset mid-operation aborts immediately to these values.
- All state updates occur only on a posedge with bit_valid=1, except err_pulse clearing and clr.
- err_pulse is high for exactly the one cycle following the posedge that sampled an erroneous bit. It is 0 otherwise, including when bit_valid=0.
- HUNT:
  - Shift bit_in into sr; the fill count increments to a maximum of 8.
  - Once 8 bits have been received and the updated sr is not 0, go to VERIFY with match count 0.
  - If sr is all-zero (the degenerate lock-up sequence), remain in HUNT with fill count held at 8.
- VERIFY:
  - Compare bit_in with pred, then shift bit_in into sr. This is self-synchronising.
  - On a match, the match count increments. When it reaches LOCK_CNT, go to LOCKED.
  - On a mismatch, set match count to 0 and stay in VERIFY.
  - If the updated sr is 0, go to HUNT with fill count 0.
  - No errors are counted in VERIFY.
- LOCKED:
  - Shift pred, not bit_in, into sr, so a single line error yields exactly one error.
  - bit_cnt increments, saturating at all-ones.
  - If bit_in != pred: err_pulse fires, err_cnt increments (saturating), and the window error count increments.
  - The window counter runs 0..WINDOW-1 and wraps. On wrap the window error count reloads to 0, or to 1 if the wrapping bit is itself an error.
  - When the window error count reaches ERR_THRESH, go to HUNT with fill count 0. locked falls in the same cycle the state changes.
- Output timing: locked and state are registered and change on the posedge that accepts the deciding bit.
- clr coincident with an error: clr wins. Counters read 0 next cycle, the error is not counted, and err_pulse still fires.
- Counter saturation: counters hold at all-ones. The window logic is unaffected by saturation.

Decomposition:
- Package prbs_pkg:
  - State enum HUNT/VERIFY/LOCKED.
  - LFSR_W=8 and the tap constants 7,5,4,2.
  - Function prbs_next_bit(sr) shared with the generator side.
- One sub-module, prbs_err_window: the window counter, window error counter and threshold compare. Inputs: step, err, restart. Output: thresh_hit.

Test Plan:
- Reset, then feed the continuous generator stream from seed 8'hA5 with bit_valid=1 -> state=VERIFY after the 8th bit; locked=1 after the 24th bit; err_pulse stays 0; bit_cnt=10 after 10 further bits.
- Same stream with bit_valid low on random cycles -> lock still occurs after exactly 24 valid bits; counters do not advance on invalid cycles.
- After lock, invert one bit -> err_pulse for 1 cycle, err_cnt=1, locked stays 1, no further errors on subsequent correct bits.
- After lock, invert 8 bits within one 64-bit window -> locked drops on the 8th error, state=HUNT, err_cnt=8. With 7 errors per window over 3 windows, locked stays 1 and err_cnt=21.
- Stream of 100 zero bits after reset -> state never leaves HUNT; locked=0.
- Assert clr on the same valid cycle as an error -> err_cnt=0 and err_pulse=1 next cycle. Assert rst while LOCKED -> all outputs 0, state=HUNT immediately.
